dense_seq_mac: RTL and testbench

//  Downstream consumer of the 6-wide level-3 encoder output: a fully connected layer, y = act(W*x + b).

---
 rtl/dense_seq_mac_pkg.sv | 35 +++
 rtl/dense_seq_mac_fxp_mac_sat.sv | 59 +++++
 rtl/dense_seq_mac.sv | 154 +++++++++++++++
 tb/tb_dense_seq_mac.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_seq_mac_pkg.sv
// ============================================================================
// Module     : dense_seq_mac_pkg
// Description: Shared fixed-point defaults, FSM encoding and saturation helpers
//              for the serial dense-layer MAC family.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package dense_seq_mac_pkg;

    localparam int DEF_BITSIZE = 16;
    localparam int DEF_FRAC    = 12;
    localparam int DEF_ACC_W   = 2 * DEF_BITSIZE + 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Representable range of a signed element of the given width
    function automatic longint fxp_sat_max(input int bits);
        return (longint'(1) <<< (bits - 1)) - longint'(1);
    endfunction

    function automatic longint fxp_sat_min(input int bits);
        return -(longint'(1) <<< (bits - 1));
    endfunction

    localparam logic signed [DEF_BITSIZE-1:0] DEF_SAT_MAX = 16'sh7FFF;
    localparam logic signed [DEF_BITSIZE-1:0] DEF_SAT_MIN = 16'sh8000;

endpackage

`default_nettype wire

// File: rtl/dense_seq_mac_fxp_mac_sat.sv
// ============================================================================
// Module     : fxp_mac_sat
// Description: Combinational signed MAC step: multiply, load-or-accumulate,
//              floor shift back to the element format, saturate, optional ReLU.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module fxp_mac_sat
    import dense_seq_mac_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int FRAC    = DEF_FRAC,
    parameter int ACC_W   = 2 * BITSIZE + 4,
    parameter int RELU    = 1
) (
    input  logic signed [BITSIZE-1:0] x_op,
    input  logic signed [BITSIZE-1:0] w_op,
    input  logic signed [BITSIZE-1:0] b_op,
    input  logic signed [ACC_W-1:0]   acc_in,
    input  logic                      load,
    output logic signed [ACC_W-1:0]   acc_next,
    output logic signed [BITSIZE-1:0] result
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(fxp_sat_max(BITSIZE));
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(fxp_sat_min(BITSIZE));

    logic signed [2*BITSIZE-1:0] w_prod;
    logic signed [ACC_W-1:0]     w_prod_ext;
    logic signed [ACC_W-1:0]     w_bias_ext;
    logic signed [ACC_W-1:0]     w_base;
    logic signed [ACC_W-1:0]     w_shift;

    assign w_prod     = x_op * w_op;
    assign w_prod_ext = {{(ACC_W - 2*BITSIZE){w_prod[2*BITSIZE-1]}}, w_prod};

    // Bias is aligned to the product's 2*FRAC binary point before the first add
    assign w_bias_ext = {{(ACC_W - BITSIZE){b_op[BITSIZE-1]}}, b_op} <<< FRAC;
    assign w_base     = load ? w_bias_ext : acc_in;
    assign acc_next   = w_base + w_prod_ext;
    assign w_shift    = acc_next >>> FRAC;

    always_comb begin
        if (w_shift > SAT_MAX) begin
            result = SAT_MAX[BITSIZE-1:0];
        end else if (w_shift < SAT_MIN) begin
            result = SAT_MIN[BITSIZE-1:0];
        end else begin
            result = w_shift[BITSIZE-1:0];
        end
        if ((RELU != 0) && result[BITSIZE-1]) begin
            result = '0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dense_seq_mac.sv
// ============================================================================
// Module     : dense_seq_mac
// Description: Fully connected layer y = act(W*x + b) computed serially with a
//              single fixed-point MAC, valid/ready on both sides.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module dense_seq_mac
    import dense_seq_mac_pkg::*;
#(
    parameter int BITSIZE = DEF_BITSIZE,
    parameter int FRAC    = DEF_FRAC,
    parameter int N_IN    = 6,
    parameter int N_OUT   = 6,
    parameter int RELU    = 1,
    parameter int ACC_W   = 2 * BITSIZE + 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BITSIZE*N_IN-1:0]         x,
    input  logic [BITSIZE*N_IN*N_OUT-1:0]   w,
    input  logic [BITSIZE*N_OUT-1:0]        b,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [BITSIZE*N_OUT-1:0]        y
);

    localparam int IW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(N_IN - 1);
    localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

    state_t                      r_state;
    state_t                      w_state_next;
    logic [BITSIZE*N_IN-1:0]     r_x;
    logic [IW-1:0]               r_i;
    logic [JW-1:0]               r_j;
    logic signed [ACC_W-1:0]     r_acc;
    logic signed [ACC_W-1:0]     w_acc_next;
    logic [BITSIZE*N_OUT-1:0]    r_y;
    logic                        r_out_valid;

    logic                        w_accept;
    logic                        w_release;
    logic                        w_last_i;
    logic                        w_last_j;
    logic signed [BITSIZE-1:0]   w_x_op;
    logic signed [BITSIZE-1:0]   w_w_op;
    logic signed [BITSIZE-1:0]   w_b_op;
    logic signed [BITSIZE-1:0]   w_result;

    assign w_last_i  = (r_i == I_LAST);
    assign w_last_j  = (r_j == J_LAST);
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign y         = r_y;

    // Operand selection: x from the captured copy, w and b straight from the held inputs
    always_comb begin
        w_x_op = r_x[BITSIZE*r_i +: BITSIZE];
        w_w_op = w[BITSIZE*(int'(r_j)*N_IN + int'(r_i)) +: BITSIZE];
        w_b_op = b[BITSIZE*r_j +: BITSIZE];
    end

    fxp_mac_sat #(
        .BITSIZE (BITSIZE),
        .FRAC    (FRAC),
        .ACC_W   (ACC_W),
        .RELU    (RELU)
    ) u_mac (
        .x_op     (w_x_op),
        .w_op     (w_w_op),
        .b_op     (w_b_op),
        .acc_in   (r_acc),
        .load     (r_i == '0),
        .acc_next (w_acc_next),
        .result   (w_result)
    );

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_MAC;
                end
            end
            S_MAC: begin
                if (w_last_i && w_last_j) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_y         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_x <= x;
                r_i <= '0;
                r_j <= '0;
            end
            if (r_state == S_MAC) begin
                r_acc <= w_acc_next;
                if (w_last_i) begin
                    r_y[BITSIZE*r_j +: BITSIZE] <= w_result;
                    r_i <= '0;
                    if (w_last_j) begin
                        r_j         <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end else begin
                    r_i <= r_i + 1'b1;
                end
            end
            if (w_release) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dense_seq_mac.sv
// ============================================================================
// Module     : tb_dense_seq_mac
// Description: Scoreboard bench driving a RELU=0 and a RELU=1 instance in lockstep.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_dense_seq_mac;

    localparam int BS  = 16;
    localparam int NI  = 6;
    localparam int NO  = 6;
    localparam int XW  = BS * NI;
    localparam int WW  = BS * NI * NO;
    localparam int BW  = BS * NO;
    localparam int LAT = NI * NO;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [XW-1:0] x = '0;
    logic [WW-1:0] w = '0;
    logic [BW-1:0] b = '0;
    logic          in_ready0, in_ready1, out_valid0, out_valid1;
    logic [BW-1:0] y0, y1;

    int  tests = 0;
    int  fails = 0;
    int  cyc   = 0;
    bit  rand_bp = 1'b0;

    typedef struct {
        logic [BW-1:0] y0;
        logic [BW-1:0] y1;
        int            acc_edge;
    } exp_t;
    exp_t sb_q[$];
    exp_t cur;
    bit   holding = 1'b0;
    bit   prev_hs = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dense_seq_mac #(.RELU(0)) dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .x(x), .w(w), .b(b), .out_valid(out_valid0), .out_ready(out_ready), .y(y0)
    );

    dense_seq_mac #(.RELU(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .x(x), .w(w), .b(b), .out_valid(out_valid1), .out_ready(out_ready), .y(y1)
    );

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the layer equation
    function automatic logic [BW-1:0] model(input logic [XW-1:0] xv, input logic [WW-1:0] wv,
                                            input logic [BW-1:0] bv, input bit relu);
        logic [BW-1:0] res;
        res = '0;
        for (int j = 0; j < NO; j++) begin
            longint acc, r;
            logic signed [BS-1:0] be, xe, we;
            be  = bv[BS*j +: BS];
            acc = longint'(be) * 4096;
            for (int i = 0; i < NI; i++) begin
                xe  = xv[BS*i +: BS];
                we  = wv[BS*(j*NI+i) +: BS];
                acc = acc + longint'(xe) * longint'(we);
            end
            r = acc >>> 12;
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            if (relu && r < 0) r = 0;
            res[BS*j +: BS] = r[BS-1:0];
        end
        return res;
    endfunction

    function automatic logic [XW-1:0] fill_x(input logic [BS-1:0] v);
        for (int i = 0; i < NI; i++) fill_x[BS*i +: BS] = v;
    endfunction
    function automatic logic [WW-1:0] fill_w(input logic [BS-1:0] v);
        for (int i = 0; i < NI*NO; i++) fill_w[BS*i +: BS] = v;
    endfunction
    function automatic logic [BW-1:0] fill_b(input logic [BS-1:0] v);
        for (int i = 0; i < NO; i++) fill_b[BS*i +: BS] = v;
    endfunction

    task automatic issue(input logic [XW-1:0] xv, input logic [WW-1:0] wv, input logic [BW-1:0] bv);
        exp_t e;
        bit   done;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            @(posedge clk); #2;
            if (in_ready0) begin
                x = xv; w = wv; b = bv; in_valid = 1'b1;
                e.y0 = model(xv, wv, bv, 1'b0);
                e.y1 = model(xv, wv, bv, 1'b1);
                e.acc_edge = cyc + 1;
                sb_q.push_back(e);
                @(posedge clk); #2;
                in_valid = 1'b0;
                x = XW'({$urandom, $urandom, $urandom});
                done = 1'b1;
            end
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL issue_timeout: in_ready never rose");
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(posedge clk); #2;
            ok = (sb_q.size() == 0) && !holding && in_ready0;
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain_timeout: %0d results outstanding", sb_q.size());
        end
    endtask

    // Monitor: pops one expectation per presented result and rechecks it every held cycle
    always @(negedge clk) begin
        if (reset) begin
            holding = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                check("in_ready_after_hs", {95'd0, in_ready0}, {95'd0, 1'b1});
                check("out_valid_after_hs", {95'd0, out_valid0}, '0);
                prev_hs = 1'b0;
            end
            if (out_valid0) begin
                if (!holding) begin
                    if (sb_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_output: y0=%h", y0);
                    end else begin
                        cur = sb_q.pop_front();
                        check("latency", BW'(cyc - cur.acc_edge), BW'(LAT));
                    end
                    holding = 1'b1;
                end
                check("y_relu0", y0, cur.y0);
                check("y_relu1", y1, cur.y1);
                check("out_valid_pair", {95'd0, out_valid1}, {95'd0, 1'b1});
                check("in_ready_busy", {95'd0, in_ready0}, '0);
                if (out_ready) begin
                    holding = 1'b0;
                    prev_hs = 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_bp) begin
            #2 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        logic [WW-1:0] wtmp;
        repeat (3) @(posedge clk);
        #2;
        check("rst_in_ready", {94'd0, in_ready0, in_ready1}, {94'd0, 2'b11});
        check("rst_out_valid", {94'd0, out_valid0, out_valid1}, '0);
        check("rst_y0", y0, '0);
        check("rst_y1", y1, '0);
        reset = 1'b0;

        // Basic 3.25 result
        issue(fill_x(16'h0800), fill_w(16'h1000), fill_b(16'h0400));
        drain();
        check("t1_value", y0, fill_b(16'h3400));

        // Negative result, with and without ReLU
        issue(fill_x(16'h0800), fill_w(16'hF000), fill_b(16'h0000));
        drain();
        // Saturation both ways
        issue(fill_x(16'h7FFF), fill_w(16'h7FFF), fill_b(16'h7FFF));
        issue(fill_x(16'h7FFF), fill_w(16'h8001), fill_b(16'h7FFF));
        drain();
        // Floor truncation on the smallest products
        issue({80'd0, 16'h0001}, fill_w(16'h0001), fill_b(16'h0000));
        issue({80'd0, 16'hFFFF}, fill_w(16'h0001), fill_b(16'h0000));
        drain();

        // Backpressure with ignored input pulses
        out_ready = 1'b0;
        issue(fill_x(16'h0C00), fill_w(16'h0400), fill_b(16'hFC00));
        for (int k = 0; k < LAT + 12; k++) begin
            @(posedge clk); #2;
            in_valid = k[0];
            x = fill_x(16'h1234);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset in the middle of a computation
        issue(fill_x(16'h0800), fill_w(16'h1000), fill_b(16'h0400));
        repeat (16) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_out_valid", {94'd0, out_valid0, out_valid1}, '0);
        check("abort_y0", y0, '0);
        check("abort_in_ready", {95'd0, in_ready0}, {95'd0, 1'b1});
        sb_q.delete();
        @(posedge clk); #2 reset = 1'b0;
        issue(fill_x(16'h0800), fill_w(16'h1000), fill_b(16'h0400));
        drain();

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        for (int t = 0; t < 25; t++) begin
            for (int k = 0; k < NI*NO; k++) begin
                wtmp[BS*k +: BS] = (t % 3 == 0) ? BS'($urandom) : BS'($urandom_range(0, 16'h1FFF) - 16'h0FFF);
            end
            issue(XW'({$urandom, $urandom, $urandom}), wtmp, BW'({$urandom, $urandom, $urandom}));
        end
        drain();
        rand_bp = 1'b0;
        #3 out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
